instr_feed_buffer: RTL and testbench

//  - Instruction queue directly upstream of the pipelined processor's Decode stage.
//  - Accepts instructions from the stimulus/source side over a valid/ready handshake.
//  - Buffers them in a circular FIFO and presents one instruction per cycle to Decode.
//  - Holds the presented instruction while the processor asserts stalled, so no instruction is lost or duplicated.

---
 rtl/instr_feed_buffer.sv | 119 +++++++++++
 tb/tb_instr_feed_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_feed_buffer.sv
// Instruction queue in front of Decode: valid/ready intake, circular FIFO, registered head presented to Decode.
// Optional build macro INSTR_FEED_BYPASS_EN forwards an instruction straight to the head register when the queue is empty.
module instr_feed_buffer #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  input  logic [INSTR_W-1:0] in_instr_i,
  output logic               in_ready_o,
  input  logic               stalled_i,
  output logic               out_valid_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic               byp_q, byp_d;

  logic               push;
  logic               pop;
  logic               pop_mem;
  logic               load;
  logic               bypass;
  logic               wr_en;
  logic [CNT_W-1:0]   avail;
  logic [PTR_W-1:0]   head_ptr;

  // Ready depends only on occupancy, reset and flush; never on stalled.
  assign in_ready_o = reset_ni && (flush_i || (cnt_q < CNT_W'(DEPTH)));

  // Next-state: byp_q marks a head entry that never occupied a FIFO slot.
  always_comb begin
    push     = in_valid_i && in_ready_o && !flush_i;
    pop      = out_valid_q && !stalled_i;
    pop_mem  = pop && !byp_q;
    load     = !out_valid_q || pop;
    avail    = cnt_q - CNT_W'(pop_mem);
    head_ptr = rd_ptr_q + PTR_W'(pop_mem);
    bypass   = 1'b0;
`ifdef INSTR_FEED_BYPASS_EN
    bypass   = push && (cnt_q == '0) && !stalled_i;
`endif
    wr_en    = push && !bypass;

    rd_ptr_d    = head_ptr;
    wr_ptr_d    = wr_ptr_q + PTR_W'(wr_en);
    cnt_d       = avail + CNT_W'(wr_en);
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    byp_d       = byp_q;

    if (load) begin
      if (bypass) begin
        out_valid_d = 1'b1;
        out_instr_d = in_instr_i;
        byp_d       = 1'b1;
      end else if (avail != '0) begin
        out_valid_d = 1'b1;
        out_instr_d = mem_q[head_ptr];
        byp_d       = 1'b0;
      end else begin
        out_valid_d = 1'b0;
        out_instr_d = '0;
        byp_d       = 1'b0;
      end
    end

    if (flush_i) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_instr_d = '0;
      byp_d       = 1'b0;
      wr_en       = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      byp_q       <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      byp_q       <= byp_d;
    end
  end

  // Storage array carries no reset; validity is tracked by count.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_instr_i;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_instr_o = out_instr_q;
  assign count_o     = cnt_q;

endmodule

// File: tb/tb_instr_feed_buffer.sv
// Self-checking bench for instr_feed_buffer: directed scenarios plus randomized streaming against a queue-based model.
module tb_instr_feed_buffer;

  localparam int DEPTH = 4;
`ifdef INSTR_FEED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        in_ready;
  logic        stalled = 1'b0;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mq holds stored entries in order; m_shown/m_word is what Decode should see.
  logic [15:0] mq[$];
  bit          m_shown = 1'b0;
  bit          m_byp   = 1'b0;
  logic [15:0] m_word  = '0;
  logic [15:0] acc_log[$];
  logic [15:0] dut_log[$];
  bit          last_acc;

  instr_feed_buffer #(.INSTR_W(16), .DEPTH(DEPTH)) dut (
    .clock_i    (clk),
    .reset_ni   (reset_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_instr_i (in_instr),
    .in_ready_o (in_ready),
    .stalled_i  (stalled),
    .out_valid_o(out_valid),
    .out_instr_o(out_instr),
    .count_o    (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit f, input bit v, input logic [15:0] w, input bit s);
    bit acc, popped, byp, can_show;
    int n;
    if (!r || f) begin
      mq.delete();
      m_shown = 1'b0;
      m_byp   = 1'b0;
      m_word  = '0;
      return;
    end
    n        = mq.size();
    acc      = v && (n < DEPTH);
    popped   = m_shown && !s;
    if (popped && !m_byp) void'(mq.pop_front());
    byp      = BYP && acc && (n == 0) && !s;
    can_show = !m_shown || popped;
    if (can_show) begin
      if (byp) begin
        m_shown = 1'b1; m_word = w; m_byp = 1'b1;
      end else if (mq.size() > 0) begin
        m_shown = 1'b1; m_word = mq[0]; m_byp = 1'b0;
      end else begin
        m_shown = 1'b0; m_word = '0; m_byp = 1'b0;
      end
    end
    if (acc) acc_log.push_back(w);
    if (acc && !byp) mq.push_back(w);
  endtask

  // One clock: drive at negedge, check ready, advance model, check registered outputs next negedge.
  task automatic step(input bit r, input bit f, input bit v, input logic [15:0] w, input bit s);
    reset_n = r; flush = f; in_valid = v; in_instr = w; stalled = s;
    #1;
    check_eq("in_ready", 32'(in_ready), 32'(r && (f || (mq.size() < DEPTH))));
    last_acc = r && !f && v && in_ready;
    if (r && !f && out_valid && !s) dut_log.push_back(out_instr);
    model_step(r, f, v, w, s);
    @(posedge clk);
    @(negedge clk);
    check_eq("out_valid", 32'(out_valid), 32'(m_shown));
    check_eq("out_instr", 32'(out_instr), 32'(m_word));
    check_eq("count", 32'(count), 32'(mq.size()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic check_log(input string tag, input logic [15:0] exp[$]);
    check_eq({tag, "_len"}, 32'(dut_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
      check_eq(tag, 32'(dut_log[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [15:0] exp_words[$];
    logic [15:0] w;
    bit          done;
    bit          v, s;

    @(negedge clk);

    // T1: reset held with in_valid high
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0);
    check_eq("t1_count", 32'(count), 32'd0);
    idle(1);

    // T2: back-to-back stream
    dut_log.delete(); acc_log.delete();
    step(1'b1, 1'b0, 1'b1, 16'h1111, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h2222, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h3333, 1'b0);
    idle(4);
    exp_words = '{16'h1111, 16'h2222, 16'h3333};
    check_log("t2_order", exp_words);
    check_eq("t2_count", 32'(count), 32'd0);

    // T3: fill under stall, fifth word blocked until stall released
    dut_log.delete(); acc_log.delete();
    exp_words = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, exp_words[i], 1'b1);
    check_eq("t3_count_full", 32'(count), 32'd4);
    step(1'b1, 1'b0, 1'b1, exp_words[4], 1'b1);
    check_eq("t3_fifth_blocked", 32'(last_acc), 32'd0);
    check_eq("t3_hold", 32'(out_instr), 32'hA001);
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      step(1'b1, 1'b0, 1'b1, exp_words[4], 1'b0);
      if (last_acc) done = 1'b1;
    end
    check_eq("t3_fifth_accepted", 32'(done), 32'd1);
    idle(8);
    check_log("t3_order", exp_words);

    // T4: full with pop in progress
    dut_log.delete(); acc_log.delete();
    exp_words = '{16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005};
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, exp_words[i], 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    check_eq("t4_full", 32'(count), 32'd4);
    step(1'b1, 1'b0, 1'b1, exp_words[4], 1'b0);
    check_eq("t4_no_push", 32'(last_acc), 32'd0);
    check_eq("t4_count_after_pop", 32'(count), 32'd3);
    step(1'b1, 1'b0, 1'b1, exp_words[4], 1'b0);
    check_eq("t4_push", 32'(last_acc), 32'd1);
    check_eq("t4_count_pushpop", 32'(count), 32'd3);
    idle(8);
    check_log("t4_order", exp_words);

    // T5: flush mid-stream drops stored and coincident words
    dut_log.delete(); acc_log.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'hC001 + 16'(i), 1'b1);
    check_eq("t5_count_pre", 32'(count), 32'd3);
    step(1'b1, 1'b1, 1'b1, 16'hC004, 1'b0);
    check_eq("t5_count", 32'(count), 32'd0);
    check_eq("t5_out_valid", 32'(out_valid), 32'd0);
    idle(4);
    check_eq("t5_nothing_out", 32'(dut_log.size()), 32'd0);

    // T6: randomized traffic with stalls through pointer wrap
    dut_log.delete(); acc_log.delete();
    w = 16'(($urandom & 32'hFF00) | 32'h1);
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 2) == 0);
      step(1'b1, 1'b0, v, w, s);
      if (last_acc) w = w + 16'd1;
    end
    idle(12);
    check_eq("t6_len", 32'(dut_log.size()), 32'(acc_log.size()));
    for (int i = 0; i < acc_log.size() && i < dut_log.size(); i++)
      check_eq("t6_order", 32'(dut_log[i]), 32'(acc_log[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
